// File: rtl/pencode_pkg.sv
// Shared types and constants for the registered priority-encoder arbiter.
package pencode_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/pencode_arb_prio_find.sv
// Combinational search for the first set bit, scanning downward from start-1
// with wrap modulo N; start = 0 begins the scan at N-1.
module prio_find #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int W = $clog2(N);

  int           p;
  logic [W-1:0] pw;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    p     = 0;
    pw    = '0;
    for (int k = 1; k <= N; k++) begin
      p = int'(start) - k;
      if (p < 0) p = p + N;
      pw = W'(p);
      if (!found && vec[pw]) begin
        found = 1'b1;
        idx   = pw;
      end
    end
  end

endmodule

// File: rtl/pencode_arb.sv
// Registered N-line priority encoder / arbiter with sticky grant, fixed or
// round-robin priority, and revoke when the granted line drops or is masked.
//
// state | meaning
// IDLE  | no live grant; arbitrate effective requests on each edge
// GRANT | Y/Valid/grant held until ack or revoke
module pencode_arb
  import pencode_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         A,
  input  logic [N-1:0]         mask,
  input  logic                 mode,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] Y,
  output logic                 Valid,
  output logic [N-1:0]         grant
);

  localparam int W = $clog2(N);

  state_t       state, state_nxt;
  logic [W-1:0] rr_ptr, rr_nxt;
  logic [W-1:0] y_nxt;
  logic         valid_nxt;
  logic [N-1:0] eff;
  logic [W-1:0] start;
  logic [W-1:0] win;
  logic         found;

  assign eff   = A & ~mask;
  // rr_ptr = 0 makes the round-robin scan identical to fixed priority.
  assign start = (mode == MODE_RR) ? rr_ptr : '0;

  prio_find #(.N(N)) u_find (
    .vec   (eff),
    .start (start),
    .idx   (win),
    .found (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Y      <= '0;
      Valid  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      Y      <= y_nxt;
      Valid  <= valid_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    valid_nxt = Valid;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (found) begin
          state_nxt = GRANT;
          y_nxt     = win;
          valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        // ack wins over revoke so the pointer always advances on service.
        if (ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          rr_nxt    = Y;
        end else if (!A[Y] || mask[Y]) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = Valid && (Y == W'(i));
    end
  end

endmodule

// File: tb/tb_pencode_arb.sv
// Directed bench for pencode_arb: an N=8 and an N=5 instance sharing clk/rst.
module tb_pencode_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a8, mask8;
  logic       mode8, ack8;
  logic [2:0] y8;
  logic       v8;
  logic [7:0] g8;
  logic [4:0] a5, mask5;
  logic       mode5, ack5;
  logic [2:0] y5;
  logic       v5;
  logic [4:0] g5;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pencode_arb #(.N(8)) u8 (
    .clk(clk), .rst(rst), .A(a8), .mask(mask8), .mode(mode8), .ack(ack8),
    .Y(y8), .Valid(v8), .grant(g8)
  );

  pencode_arb #(.N(5)) u5 (
    .clk(clk), .rst(rst), .A(a5), .mask(mask5), .mode(mode5), .ack(ack5),
    .Y(y5), .Valid(v5), .grant(g5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a8 = '0; mask8 = '0; mode8 = 1'b0; ack8 = 1'b0;
    a5 = '0; mask5 = '0; mode5 = 1'b0; ack5 = 1'b0;
    tick();
    tick();
    chk("rst_y8", y8, 0);
    chk("rst_v8", v8, 0);
    chk("rst_g8", g8, 0);
    chk("rst_v5", v5, 0);
    rst = 1'b0;

    // 1: async reset mid-grant
    a8 = 8'b0010_1101;
    tick();
    chk("t1_y", y8, 5);
    chk("t1_v", v8, 1);
    chk("t1_g", g8, 8'h20);
    rst = 1'b1;
    #1;
    chk("t1_async_y", y8, 0);
    chk("t1_async_v", v8, 0);
    chk("t1_async_g", g8, 0);
    rst = 1'b0;
    tick();
    chk("t1_rel_y", y8, 5);
    chk("t1_rel_v", v8, 1);
    chk("t1_rel_g", g8, 8'h20);
    a8 = '0; ack8 = 1'b1;
    tick();
    chk("t1_end_v", v8, 0);
    ack8 = 1'b0;

    // 2: fixed priority, sticky grant, ack gap, mask revoke
    a8 = 8'b1000_1011;
    tick();
    chk("t2_y", y8, 7);
    chk("t2_g", g8, 8'h80);
    a8 = 8'hFF; mask8 = 8'h01;
    tick();
    chk("t2_hold_y", y8, 7);
    chk("t2_hold_v", v8, 1);
    a8 = 8'b1000_1011; mask8 = '0; ack8 = 1'b1;
    tick();
    chk("t2_ack_v", v8, 0);
    ack8 = 1'b0;
    tick();
    chk("t2_regrant_y", y8, 7);
    chk("t2_regrant_v", v8, 1);
    mask8 = 8'h80;
    tick();
    chk("t2_revoke_v", v8, 0);
    tick();
    chk("t2_mask_y", y8, 3);
    chk("t2_mask_v", v8, 1);
    a8 = '0; mask8 = '0; ack8 = 1'b1;
    tick();
    ack8 = 1'b0;

    // 3: round robin from reset, all requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a8 = 8'hFF; mode8 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t3_y", y8, (k == 8) ? 7 : 7 - k);
      chk("t3_v", v8, 1);
      ack8 = 1'b1;
      tick();
      chk("t3_gap_v", v8, 0);
      ack8 = 1'b0;
    end

    // 4: wrap past 1,0 from rr_ptr = 2
    a8 = 8'b0000_0100;
    tick();
    chk("t4_setup_y", y8, 2);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    a8 = 8'b1000_0100;
    tick();
    chk("t4_wrap_y", y8, 7);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    a8 = 8'b0000_0100;
    tick();
    chk("t4_back_y", y8, 2);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;

    // 5: revoke leaves rr_ptr at 2
    mode8 = 1'b0;
    a8 = 8'b0001_0010;
    tick();
    chk("t5_y", y8, 4);
    a8 = 8'b0000_0010;
    tick();
    chk("t5_revoke_v", v8, 0);
    mode8 = 1'b1;
    a8 = 8'b0000_1010;
    tick();
    chk("t5_rrptr_y", y8, 1);
    chk("t5_rrptr_v", v8, 1);
    a8 = '0; ack8 = 1'b1;
    tick();
    ack8 = 1'b0;

    // 6: N=5 round robin, ack together with revoke
    mode5 = 1'b1;
    a5 = 5'b10001;
    tick();
    chk("t6_y", y5, 4);
    chk("t6_g", g5, 5'b10000);
    ack5 = 1'b1; a5 = 5'b00001;
    tick();
    chk("t6_ackrev_v", v5, 0);
    ack5 = 1'b0; a5 = 5'b10001;
    tick();
    chk("t6_rrptr_y", y5, 0);
    ack5 = 1'b1;
    tick();
    ack5 = 1'b0;
    tick();
    chk("t6_next_y", y5, 4);
    ack5 = 1'b1; a5 = '0;
    tick();
    ack5 = 1'b0;
    tick();
    chk("t6_zero_v", v5, 0);
    a5 = 5'h1F; mask5 = 5'h1F;
    tick();
    chk("t6_masked_v", v5, 0);
    mask5 = '0;
    tick();
    chk("t6_last_y", y5, 3);
    chk("t6_last_g", g5, 5'b01000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
